// File: rtl/d8_alu_arbiter.sv
// d8_alu_arbiter: shares one d8 ALU between two requesters.
// Round-robin grant, opcode decode, operand drive, fixed-latency wait, and a
// single-cycle response (result or illegal-op error) back to the winner.
module d8_alu_arbiter #(
  parameter int W       = 8,
  parameter int ALU_LAT = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  // requester 0
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [7:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         resp0_valid,
  output logic [W-1:0] resp0_data,
  output logic         resp0_err,
  // requester 1
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [7:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         resp1_valid,
  output logic [W-1:0] resp1_data,
  output logic         resp1_err,
  // ALU datapath
  output logic [2:0]   alu_ctrl,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Counter is at least one bit wide so ALU_LAT = 1 still elaborates.
  localparam int            CW       = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic          last_q, last_d;       // requester granted most recently
  logic          id_q, id_d;           // requester owning the current operation
  logic          illegal_q, illegal_d;
  logic [2:0]    ctrl_q, ctrl_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  result_q, result_d;

  logic          take;
  logic          grant_id;
  logic [7:0]    sel_op;
  logic [W-1:0]  sel_a, sel_b;
  logic [2:0]    sel_code;
  logic          resp_fire;

  // Opcode to ALU control; 000 doubles as the "illegal" marker.
  function automatic logic [2:0] decode_op(input logic [7:0] op);
    case (op)
      8'h01:   decode_op = 3'b001;
      8'h02:   decode_op = 3'b010;
      8'h03:   decode_op = 3'b011;
      8'h04:   decode_op = 3'b100;
      default: decode_op = 3'b000;
    endcase
  endfunction

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    grant_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    take     = (state_q == ST_IDLE) && (req0_valid || req1_valid) && !sys_rst;
    sel_op   = grant_id ? req1_op : req0_op;
    sel_a    = grant_id ? req1_a  : req0_a;
    sel_b    = grant_id ? req1_b  : req0_b;
    sel_code = decode_op(sel_op);
  end

  assign req0_ready = take && !grant_id;
  assign req1_ready = take &&  grant_id;

  // Next-state logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    illegal_d = illegal_q;
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (take) begin
          last_d = grant_id;
          id_d   = grant_id;
          if (sel_code != 3'b000) begin
            // Operands only move for legal ops, so the ALU is never driven otherwise.
            illegal_d = 1'b0;
            ctrl_d    = sel_code;
            a_d       = sel_a;
            b_d       = sel_b;
            cnt_d     = '0;
            state_d   = ST_EXEC;
          end else begin
            illegal_d = 1'b1;
            result_d  = '0;
            state_d   = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == CNT_LAST) begin
          result_d = alu_result;
          cnt_d    = '0;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset; a reset mid-operation simply aborts it.
  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      id_q      <= 1'b0;
      illegal_q <= 1'b0;
      ctrl_q    <= 3'b000;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      id_q      <= id_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  // ALU control is only live in EXEC; operands hold their last value elsewhere.
  assign alu_ctrl = (state_q == ST_EXEC) ? ctrl_q : 3'b000;
  assign alu_a    = a_q;
  assign alu_b    = b_q;

  // Response pulse steered to the owning requester only.
  assign resp_fire   = (state_q == ST_RESP);
  assign resp0_valid = resp_fire && !id_q;
  assign resp1_valid = resp_fire &&  id_q;
  assign resp0_data  = resp0_valid ? result_q : '0;
  assign resp1_data  = resp1_valid ? result_q : '0;
  assign resp0_err   = resp0_valid && illegal_q;
  assign resp1_err   = resp1_valid && illegal_q;

endmodule
